// File: rtl/wb_arbiter_pkg.sv
// Shared widths, defaults and types for the register-file writeback arbiter.
// XLEN/RFIDX_WIDTH/RFREG_NUM mirror the core-wide register file geometry.
package wb_arbiter_pkg;

    localparam int XLEN          = 32;
    localparam int RFIDX_WIDTH   = 5;
    localparam int RFREG_NUM     = 32;
    localparam int WB_FIFO_DEPTH = 2;
    localparam int WB_STARVE_MAX = 4;

    typedef struct packed {
        logic [RFIDX_WIDTH-1:0] wa;
        logic [XLEN-1:0]        wd;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_A,
        SRC_FIFO,
        SRC_BYP
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for long-latency results; head is visible combinationally, 0-cycle read.
// Push is ignored while full and pop while empty, so callers may gate loosely.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage needs no reset: the pointers alone decide what is live.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges pipeline writeback (A, wins, no backpressure) with FIFO'd long-latency results (B, valid/ready)
// onto the regfile write port, tracks pending destinations, and requests a stall on B starvation. Optional: WB_BYPASS_EN.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = WB_FIFO_DEPTH,
    parameter int STARVE_MAX = WB_STARVE_MAX
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   a_we,
    input  logic [RFIDX_WIDTH-1:0] a_wa,
    input  logic [XLEN-1:0]        a_wd,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [RFIDX_WIDTH-1:0] b_wa,
    input  logic [XLEN-1:0]        b_wd,
    input  logic                   iss_valid,
    input  logic [RFIDX_WIDTH-1:0] iss_rd,
    output logic                   rf_we,
    output logic [RFIDX_WIDTH-1:0] rf_wa,
    output logic [XLEN-1:0]        rf_wd,
    output logic [RFREG_NUM-1:0]   pend_mask,
    output logic                   wb_stall
);

    localparam int SW = $clog2(STARVE_MAX) + 1;

    logic                 w_a_eff;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_byp;
    wb_entry_t            w_b_ent;
    wb_entry_t            w_head;
    wb_src_e              w_src;
    logic [RFREG_NUM-1:0] w_set;
    logic [RFREG_NUM-1:0] w_clr;
    logic [RFREG_NUM-1:0] r_pend;
    logic [SW-1:0]        r_starve;
    logic                 r_stall;

    assign w_a_eff = a_we && (a_wa != '0);
    assign b_ready = !reset && !w_full;
    assign w_pop   = !reset && !w_a_eff && !w_empty;
    assign w_b_ent = '{wa: b_wa, wd: b_wd};

`ifdef WB_BYPASS_EN
    assign w_byp = !reset && w_empty && !w_a_eff && b_valid;
`else
    assign w_byp = 1'b0;
`endif

    // Results to x0 are acknowledged but dropped; bypassed results never occupy a slot.
    assign w_push = b_valid && b_ready && (b_wa != '0) && !w_byp;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_dat (w_b_ent),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head     (w_head)
    );

    always_comb begin
        w_src = SRC_NONE;
        if (reset)         w_src = SRC_NONE;
        else if (w_a_eff)  w_src = SRC_A;
        else if (!w_empty) w_src = SRC_FIFO;
        else if (w_byp)    w_src = SRC_BYP;
    end

    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        case (w_src)
            SRC_A:    begin rf_we = 1'b1;           rf_wa = a_wa;      rf_wd = a_wd;      end
            SRC_FIFO: begin rf_we = 1'b1;           rf_wa = w_head.wa; rf_wd = w_head.wd; end
            SRC_BYP:  begin rf_we = (b_wa != '0);   rf_wa = b_wa;      rf_wd = b_wd;      end
            default:  begin rf_we = 1'b0;           rf_wa = '0;        rf_wd = '0;        end
        endcase
    end

    // Set is applied after clear so an issue to the retiring register keeps it pending.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if ((w_src == SRC_FIFO || w_src == SRC_BYP) && rf_we) w_clr[rf_wa] = 1'b1;
        if (iss_valid && (iss_rd != '0))                      w_set[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= ((r_pend & ~w_clr) | w_set) & {{(RFREG_NUM-1){1'b1}}, 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_stall <= 1'b0;
            if (w_empty || w_pop) begin
                r_starve <= '0;
            end else if (r_starve == SW'(STARVE_MAX - 1)) begin
                r_starve <= '0;
                r_stall  <= 1'b1;
            end else begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

    assign pend_mask = r_pend;
    assign wb_stall  = r_stall;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then random traffic,
// with a queue-based reference model checked every cycle at the falling edge.
module tb_wb_arbiter;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_we;
    logic [4:0]  a_wa;
    logic [31:0] a_wd;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_wa;
    logic [31:0] b_wd;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] pend_mask;
    logic        wb_stall;

    int vectors     = 0;
    int miscompares = 0;

    ent_t        m_q[$];
    logic [31:0] m_pend  = '0;
    int          m_starve = 0;
    logic        m_stall = 1'b0;

    wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .a_we      (a_we),
        .a_wa      (a_wa),
        .a_wd      (a_wd),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_wa      (b_wa),
        .b_wd      (b_wd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .pend_mask (pend_mask),
        .wb_stall  (wb_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_we = 0; a_wa = 0; a_wd = 0;
        b_valid = 0; b_wa = 0; b_wd = 0;
        iss_valid = 0; iss_rd = 0;
    endtask

    // Reference model: outputs from queue contents and current inputs, state advanced per cycle.
    always @(negedge clk) begin
        logic        a_eff, popped, byp, acc, exp_we;
        logic [4:0]  exp_wa;
        logic [31:0] exp_wd, nxt;
        chk("pend_mask", pend_mask, m_pend);
        chk("wb_stall", {31'b0, wb_stall}, {31'b0, m_stall});
        vectors++;
        assert (!(wb_stall && a_we)) else begin
            miscompares++;
            $display("FAIL protocol_a_we_in_stall: a_we=%b wb_stall=%b, required not both", a_we, wb_stall);
        end
        if (reset) begin
            chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
            chk("rst_b_ready", {31'b0, b_ready}, 32'd0);
            m_q.delete();
            m_pend   = '0;
            m_starve = 0;
            m_stall  = 1'b0;
        end else begin
            a_eff  = a_we && (a_wa != 0);
            popped = 0; byp = 0; exp_we = 0; exp_wa = 0; exp_wd = 0;
            if (a_eff) begin
                exp_we = 1; exp_wa = a_wa; exp_wd = a_wd;
            end else if (m_q.size() > 0) begin
                exp_we = 1; exp_wa = m_q[0].wa; exp_wd = m_q[0].wd; popped = 1;
            end
`ifdef WB_BYPASS_EN
            else if (b_valid) begin
                byp = 1; exp_we = (b_wa != 0); exp_wa = b_wa; exp_wd = b_wd;
            end
`endif
            chk("rf_we", {31'b0, rf_we}, {31'b0, exp_we});
            if (exp_we) begin
                chk("rf_wa", {27'b0, rf_wa}, {27'b0, exp_wa});
                chk("rf_wd", rf_wd, exp_wd);
            end
            chk("b_ready", {31'b0, b_ready}, {31'b0, m_q.size() < DEPTH});
            acc = b_valid && (m_q.size() < DEPTH);
            nxt = m_pend;
            if (popped) nxt[m_q[0].wa] = 1'b0;
            if (byp && b_wa != 0) nxt[b_wa] = 1'b0;
            if (iss_valid && iss_rd != 0) nxt[iss_rd] = 1'b1;
            if (m_q.size() == 0 || popped) begin
                m_starve = 0; m_stall = 0;
            end else if (m_starve + 1 == STARVE_MAX) begin
                m_starve = 0; m_stall = 1;
            end else begin
                m_starve++; m_stall = 0;
            end
            if (popped) void'(m_q.pop_front());
            if (acc && !byp && b_wa != 0) m_q.push_back('{wa: b_wa, wd: b_wd});
            m_pend = nxt;
        end
    end

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #3;
        chk("post_reset_pend", pend_mask, 32'd0);
        chk("post_reset_ready", {31'b0, b_ready}, 32'd1);
        chk("post_reset_rf_we", {31'b0, rf_we}, 32'd0);

        // A only
        tick(); a_we = 1; a_wa = 5; a_wd = 32'h1234; #3;
        chk("a_we", {31'b0, rf_we}, 32'd1);
        chk("a_wa", {27'b0, rf_wa}, 32'd5);
        chk("a_wd", rf_wd, 32'h1234);
        tick(); a_wa = 0; #3;
        chk("a_x0_idle", {31'b0, rf_we}, 32'd0);

        // Issue x7, then retire it via B
        tick(); a_we = 0; iss_valid = 1; iss_rd = 7; #3;
        tick(); iss_valid = 0; b_valid = 1; b_wa = 7; b_wd = 32'hCAFE; #3;
        chk("pend7_set", {31'b0, pend_mask[7]}, 32'd1);
`ifdef WB_BYPASS_EN
        chk("byp_we", {31'b0, rf_we}, 32'd1);
        chk("byp_wa", {27'b0, rf_wa}, 32'd7);
        chk("byp_wd", rf_wd, 32'hCAFE);
        tick(); b_valid = 0; #3;
        chk("pend7_clr", {31'b0, pend_mask[7]}, 32'd0);
`else
        chk("accept_cycle_we", {31'b0, rf_we}, 32'd0);
        tick(); b_valid = 0; #3;
        chk("retire_we", {31'b0, rf_we}, 32'd1);
        chk("retire_wa", {27'b0, rf_wa}, 32'd7);
        chk("retire_wd", rf_wd, 32'hCAFE);
        chk("pend7_held", {31'b0, pend_mask[7]}, 32'd1);
        tick(); #3;
        chk("pend7_clr", {31'b0, pend_mask[7]}, 32'd0);
`endif

        // Full FIFO while A writes every cycle
        tick(); a_we = 1; a_wa = 3; a_wd = 1; b_valid = 1; b_wa = 10; b_wd = 32'hA0; #3;
        chk("fill0_ready", {31'b0, b_ready}, 32'd1);
        tick(); b_wa = 11; b_wd = 32'hA1; #3;
        chk("fill1_ready", {31'b0, b_ready}, 32'd1);
        tick(); b_wa = 12; b_wd = 32'hA2; #3;
        chk("full_ready", {31'b0, b_ready}, 32'd0);
        tick(); #3;
        chk("full_held", {31'b0, b_ready}, 32'd0);
        tick(); a_we = 0; #3;
        chk("drain0_wa", {27'b0, rf_wa}, 32'd10);
        chk("drain0_wd", rf_wd, 32'hA0);
        chk("full_pop_refuse", {31'b0, b_ready}, 32'd0);
        tick(); #3;
        chk("drain1_wa", {27'b0, rf_wa}, 32'd11);
        chk("drain1_ready", {31'b0, b_ready}, 32'd1);
        tick(); b_valid = 0; #3;
        chk("drain2_wa", {27'b0, rf_wa}, 32'd12);
        tick(); #3;
        chk("drained_we", {31'b0, rf_we}, 32'd0);

        // Starvation
        tick(); a_we = 1; a_wa = 4; a_wd = 32'h55; b_valid = 1; b_wa = 13; b_wd = 32'hBEEF; #3;
        tick(); b_valid = 0; #3;
        chk("starve1", {31'b0, wb_stall}, 32'd0);
        for (int i = 2; i <= 4; i++) begin
            tick(); #3;
            chk("starve_n", {31'b0, wb_stall}, 32'd0);
        end
        tick(); a_we = 0; #3;
        chk("stall_hi", {31'b0, wb_stall}, 32'd1);
        chk("stall_wa", {27'b0, rf_wa}, 32'd13);
        chk("stall_wd", rf_wd, 32'hBEEF);
        tick(); #3;
        chk("stall_one_cycle", {31'b0, wb_stall}, 32'd0);

        // Simultaneous set/clear on x9
        tick(); iss_valid = 1; iss_rd = 9; #3;
`ifdef WB_BYPASS_EN
        tick(); b_valid = 1; b_wa = 9; b_wd = 32'h99; #3;
`else
        tick(); iss_valid = 0; b_valid = 1; b_wa = 9; b_wd = 32'h99; #3;
        tick(); b_valid = 0; iss_valid = 1; #3;
`endif
        chk("setclr_wa", {27'b0, rf_wa}, 32'd9);
        tick(); idle(); #3;
        chk("setclr_pend9", {31'b0, pend_mask[9]}, 32'd1);

        // Reset mid-operation with a full FIFO
        tick(); a_we = 1; a_wa = 2; b_valid = 1; b_wa = 20; b_wd = 1; #3;
        tick(); b_wa = 21; #3;
        tick(); b_valid = 0; #3;
        chk("pre_reset_full", {31'b0, b_ready}, 32'd0);
        tick(); reset = 1; a_we = 0; #3;
        chk("in_reset_we", {31'b0, rf_we}, 32'd0);
        chk("in_reset_ready", {31'b0, b_ready}, 32'd0);
        tick(); reset = 0; #3;
        chk("mid_reset_pend", pend_mask, 32'd0);
        chk("mid_reset_ready", {31'b0, b_ready}, 32'd1);
        chk("mid_reset_we", {31'b0, rf_we}, 32'd0);

        // Random traffic
        repeat (3000) begin
            tick();
            reset     = ($urandom_range(0, 299) == 0);
            a_we      = wb_stall ? 1'b0 : 1'($urandom_range(0, 1));
            a_wa      = 5'($urandom_range(0, 15));
            a_wd      = $urandom;
            b_valid   = 1'($urandom_range(0, 1));
            b_wa      = 5'($urandom_range(0, 15));
            b_wd      = $urandom;
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_rd    = 5'($urandom_range(0, 15));
        end
        tick();
        reset = 0;
        idle();
        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
